// File: rtl/ysyx_23060072_mem_arbiter_if.sv
// Bus bundle shared by the IFU/LSU requesters, the memory arbiter and the data memory port.
// The arbiter takes the slave view; the environment (requesters + memory) takes the master view.
interface ysyx_23060072_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // IFU side (read only)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    // LSU side (load/store)
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    // Shared memory port
    logic              mem_req;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_ready, mem_rvalid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_ready, mem_rvalid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_23060072_mem_arbiter.sv
// IFU/LSU arbiter in front of a single-outstanding data memory port.
// LSU wins by default; after MAX_LSU_STREAK back-to-back LSU grants with the IFU waiting,
// the IFU is served next. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module ysyx_23060072_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_23060072_mem_arbiter_if.slave   bus
);
    localparam int unsigned MASK_W     = DATA_W / 8;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_LSU_STREAK);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
    typedef enum logic [1:0] {OwnNone, OwnIfu, OwnLsu} owner_e;

    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [3:0]        streak_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [MASK_W-1:0] mem_wmask_q;

    logic              ifu_resp_valid_q;
    logic              lsu_resp_valid_q;
    logic [DATA_W-1:0] ifu_rdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;

    logic              grant_lsu;
    logic              grant_ifu;
    logic              lsu_store;
    logic              capture;

    // Grant and response-capture decode; readies are held low while reset is asserted.
    always_comb begin
        grant_lsu = (state_q == StIdle) && !rst && bus.lsu_req_valid &&
                    !(bus.ifu_req_valid && (streak_q == STREAK_MAX));
        grant_ifu = (state_q == StIdle) && !rst && !grant_lsu && bus.ifu_req_valid;
        lsu_store = grant_lsu && bus.lsu_we;
        // Zero-latency memory may answer in the same cycle it accepts the request.
        capture   = bus.mem_rvalid &&
                    (((state_q == StIssue) && bus.mem_ready) || (state_q == StWait));
    end

    // Transaction FSM with registered memory-side and response-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            owner_q          <= OwnNone;
            we_q             <= 1'b0;
            streak_q         <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_lsu || grant_ifu) begin
                        owner_q     <= grant_lsu ? OwnLsu : OwnIfu;
                        we_q        <= lsu_store;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= lsu_store;
                        mem_addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                        mem_wdata_q <= lsu_store ? bus.lsu_wdata : '0;
                        mem_wmask_q <= lsu_store ? bus.lsu_wmask : '0;
                        // Only LSU wins that actually made the IFU wait count toward the streak.
                        if (grant_lsu && bus.ifu_req_valid) begin
                            streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
                        end else begin
                            streak_q <= '0;
                        end
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.mem_ready) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        state_q     <= capture ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (capture) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    ifu_resp_valid_q <= 1'b0;
                    lsu_resp_valid_q <= 1'b0;
                    owner_q          <= OwnNone;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (capture) begin
                if (owner_q == OwnIfu) begin
                    ifu_resp_valid_q <= 1'b1;
                    ifu_rdata_q      <= bus.mem_rdata;
                end else begin
                    lsu_resp_valid_q <= 1'b1;
                    lsu_rdata_q      <= we_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wmask      = mem_wmask_q;
endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: transaction-level model checked every cycle,
// directed scenarios with hand-computed literals, and a reactive memory responder.
module tb_ysyx_23060072_mem_arbiter;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_STREAK = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ysyx_23060072_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ysyx_23060072_mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_LSU_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endfunction

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h8010_0093;
    endfunction

    // ---------------- memory port drive: automatic responder or manual override
    bit          mem_auto   = 1'b1;
    int          mem_stall  = 0;
    int          mem_lat    = 1;
    logic        r_ready    = 1'b0;
    logic        r_rvalid   = 1'b0;
    logic [31:0] r_rdata    = '0;
    logic        man_ready  = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = '0;

    assign bus.mem_ready  = mem_auto ? r_ready  : man_ready;
    assign bus.mem_rvalid = mem_auto ? r_rvalid : man_rvalid;
    assign bus.mem_rdata  = mem_auto ? r_rdata  : man_rdata;

    initial begin : responder
        int          wait_cnt;
        int          lat_cnt;
        bit          pend;
        logic [31:0] paddr;
        wait_cnt = 0;
        lat_cnt  = 0;
        pend     = 1'b0;
        paddr    = '0;
        forever begin
            @(posedge clk);
            #1;
            r_ready  = 1'b0;
            r_rvalid = 1'b0;
            r_rdata  = '0;
            if (rst || !mem_auto) begin
                pend     = 1'b0;
                wait_cnt = 0;
            end else if (pend) begin
                lat_cnt--;
                if (lat_cnt <= 0) begin
                    r_rvalid = 1'b1;
                    r_rdata  = mem_val(paddr);
                    pend     = 1'b0;
                end
            end else if (bus.mem_req) begin
                if (wait_cnt < mem_stall) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    r_ready  = 1'b1;
                    if (mem_lat == 0) begin
                        r_rvalid = 1'b1;
                        r_rdata  = mem_val(bus.mem_addr);
                    end else begin
                        pend    = 1'b1;
                        lat_cnt = mem_lat;
                        paddr   = bus.mem_addr;
                    end
                end
            end
        end
    end

    // ---------------- transaction-level reference model
    // A transaction is in flight from its accept until the end of its response cycle.
    bit          m_busy      = 1'b0;
    bit          m_hs        = 1'b0;  // memory has accepted the request
    bit          m_done      = 1'b0;  // response is being presented this cycle
    int          m_owner     = 0;     // 1 = IFU, 2 = LSU
    logic        m_we        = 1'b0;
    logic [31:0] m_addr      = '0;
    logic [31:0] m_wdata     = '0;
    logic [3:0]  m_wmask     = '0;
    logic [31:0] m_ifu_rdata = '0;
    logic [31:0] m_lsu_rdata = '0;
    int          m_streak    = 0;

    function automatic int model_grant();
        if (rst || m_busy) return 0;
        if (bus.lsu_req_valid && !(bus.ifu_req_valid && m_streak >= int'(MAX_STREAK))) return 2;
        if (bus.ifu_req_valid) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_hs        <= 1'b0;
            m_done      <= 1'b0;
            m_owner     <= 0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wmask     <= '0;
            m_ifu_rdata <= '0;
            m_lsu_rdata <= '0;
            m_streak    <= 0;
        end else if (!m_busy) begin
            if (model_grant() == 2) begin
                m_busy   <= 1'b1;
                m_owner  <= 2;
                m_we     <= bus.lsu_we;
                m_addr   <= bus.lsu_addr;
                m_wdata  <= bus.lsu_we ? bus.lsu_wdata : 32'd0;
                m_wmask  <= bus.lsu_we ? bus.lsu_wmask : 4'd0;
                m_streak <= !bus.ifu_req_valid ? 0 :
                            (m_streak < int'(MAX_STREAK) ? m_streak + 1 : int'(MAX_STREAK));
            end else if (model_grant() == 1) begin
                m_busy   <= 1'b1;
                m_owner  <= 1;
                m_we     <= 1'b0;
                m_addr   <= bus.ifu_addr;
                m_wdata  <= '0;
                m_wmask  <= '0;
                m_streak <= 0;
            end
        end else if (m_done) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_hs    <= 1'b0;
            m_owner <= 0;
        end else begin
            if (bus.mem_ready) m_hs <= 1'b1;
            if ((m_hs || bus.mem_ready) && bus.mem_rvalid) begin
                m_done <= 1'b1;
                if (m_owner == 1) m_ifu_rdata <= bus.mem_rdata;
                else m_lsu_rdata <= m_we ? 32'd0 : bus.mem_rdata;
            end
        end
    end

    // ---------------- per-cycle compare against the model
    int grant_log[$];

    initial begin : compare
        int g;
        bit issuing;
        forever begin
            @(negedge clk);
            if (!rst) begin
                g       = model_grant();
                issuing = m_busy && !m_hs;
                chk("ifu_req_ready", 32'(bus.ifu_req_ready), 32'(g == 1));
                chk("lsu_req_ready", 32'(bus.lsu_req_ready), 32'(g == 2));
                chk("ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'(m_done && m_owner == 1));
                chk("lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'(m_done && m_owner == 2));
                chk("ifu_rdata", bus.ifu_rdata, m_ifu_rdata);
                chk("lsu_rdata", bus.lsu_rdata, m_lsu_rdata);
                chk("mem_req", 32'(bus.mem_req), 32'(issuing));
                chk("mem_we", 32'(bus.mem_we), 32'(issuing && m_we));
                chk("mem_addr", bus.mem_addr, issuing ? m_addr : 32'd0);
                chk("mem_wdata", bus.mem_wdata, issuing ? m_wdata : 32'd0);
                chk("mem_wmask", 32'(bus.mem_wmask), issuing ? 32'(m_wmask) : 32'd0);
                if (bus.ifu_req_ready) grant_log.push_back(1);
                if (bus.lsu_req_ready) grant_log.push_back(2);
            end
        end
    end

    // ---------------- requester tasks (hold valid and payload until ready is seen)
    task automatic do_ifu(input logic [31:0] a);
        bit got = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = a;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = bus.ifu_req_ready;
        end
        chk("ifu_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
    endtask

    task automatic do_lsu(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm);
        bit got = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = we;
        bus.lsu_addr      = a;
        bus.lsu_wdata     = wd;
        bus.lsu_wmask     = wm;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = bus.lsu_req_ready;
        end
        chk("lsu_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_we        = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
    endtask

    // Leaves the caller at the falling edge of the response cycle.
    task automatic wait_resp(input bit is_lsu, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = is_lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ifu_req_ready"}, 32'(bus.ifu_req_ready), 32'd0);
        chk({tag, ".lsu_req_ready"}, 32'(bus.lsu_req_ready), 32'd0);
        chk({tag, ".ifu_resp_valid"}, 32'(bus.ifu_resp_valid), 32'd0);
        chk({tag, ".lsu_resp_valid"}, 32'(bus.lsu_resp_valid), 32'd0);
        chk({tag, ".ifu_rdata"}, bus.ifu_rdata, 32'd0);
        chk({tag, ".lsu_rdata"}, bus.lsu_rdata, 32'd0);
        chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, ".mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios
    initial begin : stimulus
        int base;
        int exp_order[11];
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2};

        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_we        = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single IFU read, one-cycle memory latency
        do_ifu(32'h8000_0000);
        @(negedge clk);
        chk("t1.mem_req", 32'(bus.mem_req), 32'd1);
        chk("t1.mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("t1.mem_we", 32'(bus.mem_we), 32'd0);
        chk("t1.mem_wmask", 32'(bus.mem_wmask), 32'd0);
        wait_resp(1'b0, "t1.ifu_resp");
        chk("t1.ifu_rdata", bus.ifu_rdata, 32'h0010_0093);
        chk("t1.lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd0);
        @(negedge clk);
        chk("t1.ifu_resp_pulse", 32'(bus.ifu_resp_valid), 32'd0);
        @(posedge clk);
        #1;

        // IFU and LSU valid together: LSU first, then IFU
        base = grant_log.size();
        fork
            do_lsu(1'b0, 32'h0000_0300, 32'd0, 4'd0);
            do_ifu(32'h8000_0004);
        join
        wait_resp(1'b0, "t3.ifu_resp");
        chk("t3.ifu_rdata", bus.ifu_rdata, 32'h0010_0097);
        chk("t3.lsu_rdata_held", bus.lsu_rdata, 32'h8010_0393);
        chk("t3.grants", 32'(grant_log.size() - base), 32'd2);
        chk("t3.first_lsu", 32'(grant_log[base]), 32'd2);
        chk("t3.then_ifu", 32'(grant_log[base + 1]), 32'd1);
        @(posedge clk);
        #1;

        // Store stalled three cycles by the memory
        mem_stall = 3;
        do_lsu(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2.mem_req", 32'(bus.mem_req), 32'd1);
            chk("t2.mem_we", 32'(bus.mem_we), 32'd1);
            chk("t2.mem_addr", bus.mem_addr, 32'h0000_0100);
            chk("t2.mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t2.mem_wmask", 32'(bus.mem_wmask), 32'h3);
        end
        wait_resp(1'b1, "t2.lsu_resp");
        chk("t2.lsu_rdata", bus.lsu_rdata, 32'd0);
        @(negedge clk);
        chk("t2.lsu_resp_pulse", 32'(bus.lsu_resp_valid), 32'd0);
        mem_stall = 0;
        @(posedge clk);
        #1;

        // Anti-starvation: IFU held valid twice, LSU streams nine requests
        base = grant_log.size();
        fork
            begin
                do_ifu(32'h8000_0008);
                do_ifu(32'h8000_000C);
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    do_lsu(1'b0, 32'h0000_0400 + 32'(4 * k), 32'd0, 4'd0);
                end
            end
        join
        wait_resp(1'b1, "t4.last_lsu_resp");
        chk("t4.grants", 32'(grant_log.size() - base), 32'd11);
        for (int i = 0; i < 11; i++) begin
            chk("t4.order", 32'(grant_log[base + i]), 32'(exp_order[i]));
        end
        @(posedge clk);
        #1;

        // Zero-latency memory: response the cycle after the handshake
        mem_lat = 0;
        do_lsu(1'b0, 32'h0000_0200, 32'd0, 4'd0);
        @(negedge clk);
        chk("t5.mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        chk("t5.lsu_resp", 32'(bus.lsu_resp_valid), 32'd1);
        chk("t5.lsu_rdata", bus.lsu_rdata, 32'h8010_0293);
        mem_lat = 1;
        @(posedge clk);
        #1;
        // Spurious rvalid while idle
        mem_auto   = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t5.spurious_ifu", 32'(bus.ifu_resp_valid), 32'd0);
        chk("t5.spurious_lsu", 32'(bus.lsu_resp_valid), 32'd0);
        @(posedge clk);
        #1;
        man_rvalid = 1'b0;
        man_rdata  = '0;
        @(negedge clk);
        chk("t5.after_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
        chk("t5.after_lsu_rdata", bus.lsu_rdata, 32'h8010_0293);
        chk("t5.after_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;

        // Reset during WAIT, then a late rvalid, then a fresh IFU read
        do_ifu(32'h8000_0010);
        man_ready = 1'b1;
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        @(negedge clk);
        chk("t6.in_wait", 32'(bus.mem_req), 32'd0);
        #2;
        rst               = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0010;
        #1;
        check_all_zero("t6.async_rst");
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        rst               = 1'b0;
        man_rvalid        = 1'b1;
        man_rdata         = 32'h1234_5678;
        @(posedge clk);
        #1;
        man_rvalid = 1'b0;
        man_rdata  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6.no_late_resp", 32'(bus.ifu_resp_valid), 32'd0);
            chk("t6.no_late_rdata", bus.ifu_rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        do_ifu(32'h8000_0000);
        wait_resp(1'b0, "t6.fresh_resp");
        chk("t6.fresh_rdata", bus.ifu_rdata, 32'h0010_0093);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
